median_filter_stream: RTL and testbench
=======================================

# median_filter_stream

Streaming 3x3 rank filter for raster pixel data, the parametrised successor to the fixed nine-input 8-bit median filter. It accepts one pixel per valid cycle in row-major order and builds 3x3 windows internally with two line buffers. Each window runs through a pipelined sorting network that returns the median, minimum or maximum, or the centre pixel unchanged. It sits between a pixel source (camera or frame reader) and downstream image stages, and produces one output per interior pixel of the frame.

## Interface

Parameters:
- DATA_W, 8, pixel width in bits (unsigned)
- IMG_W, 640, pixels per line; must be ≥3
- IMG_H, 480, lines per frame; must be ≥3

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  one clock; reset is synchronous and active-high
- s_valid  in  1  input pixel valid; gaps are allowed, no backpressure
- s_sof  in  1  qualifies s_valid; marks the first pixel of a frame
- s_data  in  DATA_W  input pixel
- mode  in  2  0 median, 1 min, 2 max, 3 bypass (centre pixel)
- m_valid  out  1  output pixel valid
- m_sof  out  1  first output of a frame
- m_eol  out  1  last output of an output line
- m_data  out  DATA_W  filtered pixel

## Operation

- **Accept.** A pixel is accepted on any edge with s_valid=1. The col and row counters track the pixel's position.
- **Counter update.**
  - s_valid with s_sof=1 forces this pixel to (row 0, col 0).
  - Otherwise col increments. At IMG_W-1, col wraps to 0 and row increments.
  - After pixel (IMG_H-1, IMG_W-1), the frame is complete. Further pixels without s_sof are discarded: no buffer writes, no output.
- **Line buffers.** Two buffers of IMG_W×DATA_W, indexed by col, hold the rows r-1 and r-2. Each accepted pixel reads both buffers at col, then shifts the column into a 3x3 register window.
- **Window completion.** On acceptance of pixel (r,c) with r≥2 and c≥2, the window centred at (r-1,c-1) is complete and enters the sort pipeline. mode is captured with that window.
- **Output count.** A frame produces (IMG_W-2)×(IMG_H-2) outputs. Border pixels produce no output.
- **Output flags.**
  - m_sof=1 for the window at centre (1,1).
  - m_eol=1 for centre column IMG_W-2.
- **Sort network** (unsigned compares, no width growth):
  - S1: sort each window column into lo/mid/hi.
  - S2: compute three values:
    - maxlo = max of the three lo
    - medmid = median of the three mid
    - minhi = min of the three hi
    - Also compute min of the lo values, max of the hi values, and forward the centre pixel.
  - S3: median = median(maxlo, medmid, minhi). Select on the captured mode.
- **Mid-frame s_sof.** Aborts the current frame and restarts counters. Windows already in the pipeline still complete and are output. Stale line-buffer contents are never used, because row<2 gates window completion.
- **Reset.** Counters go to 0, the pipeline valid bits clear, and the frame is marked complete (awaiting s_sof). Outputs read m_valid=0, m_sof=0, m_eol=0, m_data=0. Line-buffer RAM contents need not be cleared.

## Timing

- **Latency.** If the completing pixel is accepted at edge k, the window register loads at edge k. S1 loads at k+1, S2 at k+2, and the output register at k+3. m_valid is high for exactly one cycle after edge k+3.
- **Output registers.** m_data, m_sof and m_eol are registered and valid only with m_valid. When m_valid=0, m_data holds its last value.
- **Throughput.** One pixel per cycle. Input gaps propagate as output gaps. The pipeline advances every cycle regardless of s_valid, so latency is constant.
- **mode timing.** A mode change applies to windows completed on or after the edge where the new value is sampled. In-flight windows keep their captured mode.
- **rst vs s_valid.** rst asserted on the same edge as s_valid wins: the pixel is dropped.

## Structure

- **Package median_pkg:**
  - mode encodings MODE_MEDIAN=0, MODE_MIN=1, MODE_MAX=2, MODE_BYPASS=3
  - localparam helpers for counter widths ($clog2(IMG_W), $clog2(IMG_H))
- **Sub-module sort3.** Combinational 3-element sorter, parametrised by DATA_W, outputs lo/mid/hi. It is instantiated for the S1 column sorts and for the S2/S3 median-of-three.
- **Line buffers.** Inferred RAM (one write port, one read port) in the top module.

## Test plan

- **Basic median.** IMG_W=4, IMG_H=4, DATA_W=8; frame 0..15 row-major, mode=0, continuous valid → m_data 5,6,9,10. m_sof on the first output, m_eol on the 2nd and 4th. First m_valid 3 edges after pixel 10 is accepted.
- **Modes.** Same frame, mode=1 → 0,1,4,5. mode=2 → 10,11,14,15. mode=3 → 5,6,9,10.
- **Impulse noise.** 3x3 frame all 20 except centre 255, mode=0 → single output 20 with m_sof=1 and m_eol=1.
- **Input gaps.** Frame 0..15 with s_valid toggling 1,0,1,0 → same four values. Spacing matches the input spacing; latency still 3 edges.
- **Frame boundaries.**
  - Mid-frame s_sof after 6 pixels, then a full frame → no outputs from the aborted frame, four correct outputs from the new frame.
  - 3 extra pixels after frame end without s_sof → ignored.
- **Reset.**
  - rst for one cycle mid-frame → outputs zero, m_valid=0.
  - Pixels without s_sof after reset → ignored.
  - A new s_sof frame after reset → correct results.

Source files
------------

// File: rtl/median_filter_stream_pkg.sv
// Shared types and helpers for the streaming 3x3 rank filter.
package median_pkg;

   // Filter selection applied to each completed window
   typedef enum logic [1:0] {
      MODE_MEDIAN = 2'd0,
      MODE_MIN    = 2'd1,
      MODE_MAX    = 2'd2,
      MODE_BYPASS = 2'd3
   } mode_t;

   // Frame tracking: waiting for s_sof, or inside a frame
   typedef enum logic {
      FR_WAIT = 1'b0,
      FR_RUN  = 1'b1
   } frame_state_t;

   localparam int MIN_DIM = 3;

   // Counter width for a dimension of n positions
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/median_filter_stream_if.sv
// Pixel stream in/out bundle for median_filter_stream.
interface median_filter_stream_if #(
   parameter int DATA_W = 8
);
   logic              s_valid;
   logic              s_sof;
   logic [DATA_W-1:0] s_data;
   logic [1:0]        mode;
   logic              m_valid;
   logic              m_sof;
   logic              m_eol;
   logic [DATA_W-1:0] m_data;

   // Pixel source / result sink side
   modport master (
      output s_valid, s_sof, s_data, mode,
      input  m_valid, m_sof, m_eol, m_data
   );

   // Filter side
   modport slave (
      input  s_valid, s_sof, s_data, mode,
      output m_valid, m_sof, m_eol, m_data
   );
endinterface

// File: rtl/median_filter_stream_sort3.sv
// Combinational unsigned 3-element sorter.
module sort3 #(
   parameter int DATA_W = 8
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [DATA_W-1:0] c,
   output logic [DATA_W-1:0] lo,
   output logic [DATA_W-1:0] mid,
   output logic [DATA_W-1:0] hi
);
   logic [DATA_W-1:0] x0, x1, y1;

   // Order a/b, merge c into the upper half, then settle lo/mid
   always_comb begin
      x0  = (a < b) ? a : b;
      x1  = (a < b) ? b : a;
      y1  = (x1 < c) ? x1 : c;
      hi  = (x1 < c) ? c : x1;
      lo  = (x0 < y1) ? x0 : y1;
      mid = (x0 < y1) ? y1 : x0;
   end
endmodule

// File: rtl/median_filter_stream.sv
// Streaming 3x3 median/min/max/bypass filter with two line buffers
// and a three-stage sorting pipeline (window -> S1 -> S2 -> output).
module median_filter_stream
   import median_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int IMG_W  = 640,
   parameter int IMG_H  = 480
) (
   input logic                     clk,
   input logic                     rst,
   median_filter_stream_if.slave   bus
);
   localparam int COL_W = cnt_w(IMG_W);
   localparam int ROW_W = cnt_w(IMG_H);
   localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_W - 1);
   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_H - 1);

   typedef logic [DATA_W-1:0] pix_t;

   frame_state_t     state, state_nxt;
   logic [COL_W-1:0] col, col_nxt, cur_col;
   logic [ROW_W-1:0] row, row_nxt, cur_row;
   logic             accept, win_done;

   pix_t lb1 [IMG_W];
   pix_t lb2 [IMG_W];
   pix_t lb1_rd, lb2_rd;

   pix_t  w_top [3];
   pix_t  w_mid [3];
   pix_t  w_bot [3];
   logic  win_v, win_sof, win_eol;
   mode_t win_mode;

   pix_t  c_lo [3];
   pix_t  c_mid [3];
   pix_t  c_hi [3];
   pix_t  s1_lo [3];
   pix_t  s1_mid [3];
   pix_t  s1_hi [3];
   pix_t  s1_ctr;
   logic  s1_v, s1_sof, s1_eol;
   mode_t s1_mode;

   pix_t  lo_min, lo_max, lo_mid, mid_lo, mid_med, mid_hi, hi_min, hi_mid, hi_max;
   pix_t  s2_maxlo, s2_medmid, s2_minhi, s2_min, s2_max, s2_ctr;
   logic  s2_v, s2_sof, s2_eol;
   mode_t s2_mode;

   pix_t  fin_lo, fin_med, fin_hi, res;
   logic  unused_sort;

   // Frame position tracking: s_sof forces (0,0); pixels after a completed frame are dropped
   always_comb begin
      state_nxt = state;
      col_nxt   = col;
      row_nxt   = row;
      cur_col   = bus.s_sof ? '0 : col;
      cur_row   = bus.s_sof ? '0 : row;
      accept    = bus.s_valid && (bus.s_sof || (state == FR_RUN));
      if (accept) begin
         state_nxt = FR_RUN;
         if (cur_col == LAST_COL) begin
            col_nxt = '0;
            if (cur_row == LAST_ROW) begin
               row_nxt   = '0;
               state_nxt = FR_WAIT;
            end else begin
               row_nxt = cur_row + ROW_W'(1);
            end
         end else begin
            col_nxt = cur_col + COL_W'(1);
            row_nxt = cur_row;
         end
      end
      win_done = accept && (cur_row >= ROW_W'(2)) && (cur_col >= COL_W'(2));
      lb1_rd   = lb1[cur_col];
      lb2_rd   = lb2[cur_col];
   end

   // Frame state and counters
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= FR_WAIT;
         col   <= '0;
         row   <= '0;
      end else begin
         state <= state_nxt;
         col   <= col_nxt;
         row   <= row_nxt;
      end
   end

   // Line buffers: lb1 holds row r-1, lb2 holds row r-2
   always_ff @(posedge clk) begin
      if (accept && !rst) begin
         lb2[cur_col] <= lb1_rd;
         lb1[cur_col] <= bus.s_data;
      end
   end

   // 3x3 window shift: newest column enters at index 2
   always_ff @(posedge clk) begin
      if (accept && !rst) begin
         w_top[0] <= w_top[1];
         w_top[1] <= w_top[2];
         w_top[2] <= lb2_rd;
         w_mid[0] <= w_mid[1];
         w_mid[1] <= w_mid[2];
         w_mid[2] <= lb1_rd;
         w_bot[0] <= w_bot[1];
         w_bot[1] <= w_bot[2];
         w_bot[2] <= bus.s_data;
      end
   end

   // Window control: valid, frame flags and captured mode
   always_ff @(posedge clk) begin
      win_sof  <= (cur_row == ROW_W'(2)) && (cur_col == COL_W'(2));
      win_eol  <= (cur_col == LAST_COL);
      win_mode <= mode_t'(bus.mode);
      if (rst) win_v <= 1'b0;
      else     win_v <= win_done;
   end

   for (genvar i = 0; i < 3; i++) begin : g_col_sort
      sort3 #(.DATA_W(DATA_W)) u_col (
         .a(w_top[i]), .b(w_mid[i]), .c(w_bot[i]),
         .lo(c_lo[i]), .mid(c_mid[i]), .hi(c_hi[i])
      );
   end

   // S1: per-column sorted values
   always_ff @(posedge clk) begin
      s1_lo   <= c_lo;
      s1_mid  <= c_mid;
      s1_hi   <= c_hi;
      s1_ctr  <= w_mid[1];
      s1_sof  <= win_sof;
      s1_eol  <= win_eol;
      s1_mode <= win_mode;
      if (rst) s1_v <= 1'b0;
      else     s1_v <= win_v;
   end

   sort3 #(.DATA_W(DATA_W)) u_lo (
      .a(s1_lo[0]), .b(s1_lo[1]), .c(s1_lo[2]),
      .lo(lo_min), .mid(lo_mid), .hi(lo_max)
   );
   sort3 #(.DATA_W(DATA_W)) u_mid (
      .a(s1_mid[0]), .b(s1_mid[1]), .c(s1_mid[2]),
      .lo(mid_lo), .mid(mid_med), .hi(mid_hi)
   );
   sort3 #(.DATA_W(DATA_W)) u_hi (
      .a(s1_hi[0]), .b(s1_hi[1]), .c(s1_hi[2]),
      .lo(hi_min), .mid(hi_mid), .hi(hi_max)
   );

   // S2: max of lows, median of mids, min of highs, plus global min/max and centre
   always_ff @(posedge clk) begin
      s2_maxlo  <= lo_max;
      s2_medmid <= mid_med;
      s2_minhi  <= hi_min;
      s2_min    <= lo_min;
      s2_max    <= hi_max;
      s2_ctr    <= s1_ctr;
      s2_sof    <= s1_sof;
      s2_eol    <= s1_eol;
      s2_mode   <= s1_mode;
      if (rst) s2_v <= 1'b0;
      else     s2_v <= s1_v;
   end

   sort3 #(.DATA_W(DATA_W)) u_fin (
      .a(s2_maxlo), .b(s2_medmid), .c(s2_minhi),
      .lo(fin_lo), .mid(fin_med), .hi(fin_hi)
   );

   assign unused_sort = ^{lo_mid, mid_lo, mid_hi, hi_mid, fin_lo, fin_hi};

   // S3 result select on the mode captured with the window
   always_comb begin
      res = s2_ctr;
      case (s2_mode)
         MODE_MEDIAN: res = fin_med;
         MODE_MIN:    res = s2_min;
         MODE_MAX:    res = s2_max;
         default:     res = s2_ctr;
      endcase
   end

   // Output register: data holds its last value between valid outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.m_valid <= 1'b0;
         bus.m_sof   <= 1'b0;
         bus.m_eol   <= 1'b0;
         bus.m_data  <= '0;
      end else begin
         bus.m_valid <= s2_v;
         bus.m_sof   <= s2_v && s2_sof;
         bus.m_eol   <= s2_v && s2_eol;
         if (s2_v) bus.m_data <= res;
      end
   end

endmodule

// File: tb/tb_median_filter_stream.sv
// Directed self-checking bench for median_filter_stream (4x4 and 3x3 frames).
module tb_median_filter_stream;
   import median_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   median_filter_stream_if #(.DATA_W(8)) bus ();
   median_filter_stream_if #(.DATA_W(8)) bus3 ();

   median_filter_stream #(.DATA_W(8), .IMG_W(4), .IMG_H(4)) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );
   median_filter_stream #(.DATA_W(8), .IMG_W(3), .IMG_H(3)) dut3 (
      .clk(clk), .rst(rst), .bus(bus3)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [7:0] q_data [$];
   logic       q_sof  [$];
   logic       q_eol  [$];
   int         q_cyc  [$];
   logic [7:0] q3_data [$];
   logic       q3_sof  [$];
   logic       q3_eol  [$];

   logic [7:0] pix [16];
   int         acc [16];
   int         ci  [4] = '{10, 11, 14, 15};

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bus.m_valid === 1'b1) begin
         q_data.push_back(bus.m_data);
         q_sof.push_back(bus.m_sof);
         q_eol.push_back(bus.m_eol);
         q_cyc.push_back(cyc);
      end
      if (bus3.m_valid === 1'b1) begin
         q3_data.push_back(bus3.m_data);
         q3_sof.push_back(bus3.m_sof);
         q3_eol.push_back(bus3.m_eol);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic drive(input logic [7:0] d, input logic sof, output int e);
      @(negedge clk);
      bus.s_valid = 1'b1;
      bus.s_sof   = sof;
      bus.s_data  = d;
      e = cyc + 1;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         bus.s_valid = 1'b0;
         bus.s_sof   = 1'b0;
      end
   endtask

   task automatic play(input int gap);
      for (int i = 0; i < 16; i++) begin
         drive(pix[i], (i == 0), acc[i]);
         if (gap != 0) idle(1);
      end
      idle(6);
   endtask

   task automatic clear_q;
      q_data.delete(); q_sof.delete(); q_eol.delete(); q_cyc.delete();
      q3_data.delete(); q3_sof.delete(); q3_eol.delete();
   endtask

   task automatic load_ramp;
      for (int i = 0; i < 16; i++) pix[i] = 8'(i);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      total++; if (bus.m_valid !== 1'b0) begin bad++; $display("FAIL reset_m_valid got=%b want=0", bus.m_valid); end
      total++; if (bus.m_sof !== 1'b0) begin bad++; $display("FAIL reset_m_sof got=%b want=0", bus.m_sof); end
      total++; if (bus.m_eol !== 1'b0) begin bad++; $display("FAIL reset_m_eol got=%b want=0", bus.m_eol); end
      total++; if (bus.m_data !== 8'd0) begin bad++; $display("FAIL reset_m_data got=%0d want=0", bus.m_data); end
      total++; if (bus3.m_data !== 8'd0) begin bad++; $display("FAIL reset3_m_data got=%0d want=0", bus3.m_data); end
      rst = 1'b0;
   endtask

   task automatic test_median;
      logic [7:0] exp_d [4] = '{8'd5, 8'd6, 8'd9, 8'd10};
      bus.mode = 2'd0;
      load_ramp();
      clear_q();
      play(0);
      total++; if (q_data.size() != 4) begin bad++; $display("FAIL median_count got=%0d want=4", q_data.size()); end
      for (int i = 0; i < 4; i++) begin
         if (i < q_data.size()) begin
            total++; if (q_data[i] !== exp_d[i]) begin bad++; $display("FAIL median_data[%0d] got=%0d want=%0d", i, q_data[i], exp_d[i]); end
            total++; if (q_sof[i] !== (i == 0)) begin bad++; $display("FAIL median_sof[%0d] got=%b want=%b", i, q_sof[i], (i == 0)); end
            total++; if (q_eol[i] !== (i % 2 == 1)) begin bad++; $display("FAIL median_eol[%0d] got=%b want=%b", i, q_eol[i], (i % 2 == 1)); end
            total++; if (q_cyc[i] != acc[ci[i]] + 3) begin bad++; $display("FAIL median_latency[%0d] got=%0d want=%0d", i, q_cyc[i], acc[ci[i]] + 3); end
         end
      end
   endtask

   task automatic test_extra_pixels;
      int e;
      clear_q();
      for (int i = 0; i < 3; i++) drive(8'(50 + i), 1'b0, e);
      idle(8);
      total++; if (q_data.size() != 0) begin bad++; $display("FAIL extra_pixels_count got=%0d want=0", q_data.size()); end
   endtask

   task automatic test_modes;
      logic [1:0] md  [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd3};
      logic       scr [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      logic [7:0] exp_t [5][4] = '{'{8'd0, 8'd1, 8'd4, 8'd5},
                                   '{8'd10, 8'd11, 8'd14, 8'd15},
                                   '{8'd5, 8'd6, 8'd9, 8'd10},
                                   '{8'd5, 8'd4, 8'd4, 8'd6},
                                   '{8'd8, 8'd4, 8'd0, 8'd9}};
      logic [7:0] scr_pix [16] = '{8'd9, 8'd1, 8'd7, 8'd3,
                                   8'd2, 8'd8, 8'd4, 8'd6,
                                   8'd5, 8'd0, 8'd9, 8'd1,
                                   8'd3, 8'd7, 8'd2, 8'd8};
      for (int t = 0; t < 5; t++) begin
         if (scr[t]) pix = scr_pix;
         else        load_ramp();
         bus.mode = md[t];
         clear_q();
         play(0);
         total++; if (q_data.size() != 4) begin bad++; $display("FAIL modes_count[%0d] got=%0d want=4", t, q_data.size()); end
         for (int i = 0; i < 4; i++) begin
            if (i < q_data.size()) begin
               total++; if (q_data[i] !== exp_t[t][i]) begin bad++; $display("FAIL modes_data[%0d][%0d] mode=%0d got=%0d want=%0d", t, i, md[t], q_data[i], exp_t[t][i]); end
            end
         end
      end
      bus.mode = 2'd0;
   endtask

   task automatic test_impulse;
      bus3.mode = 2'd0;
      clear_q();
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         bus3.s_valid = 1'b1;
         bus3.s_sof   = (i == 0);
         bus3.s_data  = (i == 4) ? 8'd255 : 8'd20;
      end
      repeat (6) begin
         @(negedge clk);
         bus3.s_valid = 1'b0;
         bus3.s_sof   = 1'b0;
      end
      total++; if (q3_data.size() != 1) begin bad++; $display("FAIL impulse_count got=%0d want=1", q3_data.size()); end
      if (q3_data.size() > 0) begin
         total++; if (q3_data[0] !== 8'd20) begin bad++; $display("FAIL impulse_data got=%0d want=20", q3_data[0]); end
         total++; if (q3_sof[0] !== 1'b1) begin bad++; $display("FAIL impulse_sof got=%b want=1", q3_sof[0]); end
         total++; if (q3_eol[0] !== 1'b1) begin bad++; $display("FAIL impulse_eol got=%b want=1", q3_eol[0]); end
      end
   endtask

   task automatic test_gaps;
      logic [7:0] exp_d [4] = '{8'd5, 8'd6, 8'd9, 8'd10};
      bus.mode = 2'd0;
      load_ramp();
      clear_q();
      play(1);
      total++; if (q_data.size() != 4) begin bad++; $display("FAIL gaps_count got=%0d want=4", q_data.size()); end
      for (int i = 0; i < 4; i++) begin
         if (i < q_data.size()) begin
            total++; if (q_data[i] !== exp_d[i]) begin bad++; $display("FAIL gaps_data[%0d] got=%0d want=%0d", i, q_data[i], exp_d[i]); end
            total++; if (q_cyc[i] != acc[ci[i]] + 3) begin bad++; $display("FAIL gaps_latency[%0d] got=%0d want=%0d", i, q_cyc[i], acc[ci[i]] + 3); end
         end
      end
   endtask

   task automatic test_mid_sof;
      logic [7:0] exp_d [4] = '{8'd5, 8'd6, 8'd9, 8'd10};
      int e;
      bus.mode = 2'd0;
      clear_q();
      for (int i = 0; i < 6; i++) drive(8'(200 + i), (i == 0), e);
      load_ramp();
      play(0);
      total++; if (q_data.size() != 4) begin bad++; $display("FAIL mid_sof_count got=%0d want=4", q_data.size()); end
      for (int i = 0; i < 4; i++) begin
         if (i < q_data.size()) begin
            total++; if (q_data[i] !== exp_d[i]) begin bad++; $display("FAIL mid_sof_data[%0d] got=%0d want=%0d", i, q_data[i], exp_d[i]); end
         end
      end
      total++; if ((q_sof.size() > 0) && (q_sof[0] !== 1'b1)) begin bad++; $display("FAIL mid_sof_flag got=%b want=1", q_sof[0]); end
   endtask

   task automatic test_reset_mid;
      logic [7:0] exp_d [4] = '{8'd5, 8'd6, 8'd9, 8'd10};
      int e;
      bus.mode = 2'd0;
      load_ramp();
      clear_q();
      for (int i = 0; i < 12; i++) drive(pix[i], (i == 0), e);
      idle(5);
      total++; if (bus.m_data !== 8'd6) begin bad++; $display("FAIL pre_reset_hold got=%0d want=6", bus.m_data); end
      // Reset edge coincides with a start-of-frame pixel, which must be dropped
      @(negedge clk);
      rst = 1'b1;
      bus.s_valid = 1'b1;
      bus.s_sof   = 1'b1;
      bus.s_data  = 8'd77;
      @(negedge clk);
      rst = 1'b0;
      bus.s_valid = 1'b0;
      bus.s_sof   = 1'b0;
      total++; if (bus.m_valid !== 1'b0) begin bad++; $display("FAIL mid_reset_m_valid got=%b want=0", bus.m_valid); end
      total++; if (bus.m_data !== 8'd0) begin bad++; $display("FAIL mid_reset_m_data got=%0d want=0", bus.m_data); end
      clear_q();
      for (int i = 0; i < 16; i++) drive(pix[i], 1'b0, e);
      idle(6);
      total++; if (q_data.size() != 0) begin bad++; $display("FAIL post_reset_nosof_count got=%0d want=0", q_data.size()); end
      clear_q();
      play(0);
      total++; if (q_data.size() != 4) begin bad++; $display("FAIL post_reset_count got=%0d want=4", q_data.size()); end
      for (int i = 0; i < 4; i++) begin
         if (i < q_data.size()) begin
            total++; if (q_data[i] !== exp_d[i]) begin bad++; $display("FAIL post_reset_data[%0d] got=%0d want=%0d", i, q_data[i], exp_d[i]); end
         end
      end
   endtask

   initial begin
      rst          = 1'b1;
      bus.s_valid  = 1'b0;
      bus.s_sof    = 1'b0;
      bus.s_data   = '0;
      bus.mode     = 2'd0;
      bus3.s_valid = 1'b0;
      bus3.s_sof   = 1'b0;
      bus3.s_data  = '0;
      bus3.mode    = 2'd0;
      test_reset();
      test_median();
      test_extra_pixels();
      test_modes();
      test_impulse();
      test_gaps();
      test_mid_sof();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
